// File: rtl/matrix_c_result_streamer.sv
// Captures the MAT_DIM x MAT_DIM result matrix C, then streams it out row-major over valid/ready.
// Optional macro ROW_CHECKSUM_EN appends a per-row checksum beat (out_col == MAT_DIM) after each row.
module matrix_c_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_DIM    = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_WriteMat_C,
  input  logic [3:0]            rowAddr_C,
  input  logic [3:0]            colAddr_C,
  input  logic [DATA_WIDTH-1:0] writeData_C,
  input  logic                  resultIsInvalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_row,
  output logic [3:0]            out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [6:0]            fill_count,
  output logic                  invalid_seen,
  output logic                  addr_err,
  output logic                  overrun_err
);

  localparam int DEPTH = MAT_DIM * MAT_DIM;
  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam logic [3:0] MAX_ROW  = 4'(MAT_DIM - 1);
  localparam logic [3:0] ELEM_END = 4'(MAT_DIM - 1);
`ifdef ROW_CHECKSUM_EN
  localparam logic [3:0] LAST_COL = 4'(MAT_DIM);
`else
  localparam logic [3:0] LAST_COL = 4'(MAT_DIM - 1);
`endif

  typedef enum logic [1:0] {COLLECT, DRAIN, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      filled;
  logic [3:0]            ptr_row;
  logic [3:0]            ptr_col;
  logic                  in_range;
  logic                  accept;
  logic                  xfer;
  logic                  at_last;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] elem_data;

  assign in_range  = ({1'b0, rowAddr_C} < 5'(MAT_DIM)) && ({1'b0, colAddr_C} < 5'(MAT_DIM));
  assign accept    = (state == COLLECT) && en_WriteMat_C && in_range;
  assign wr_idx    = IDX_W'(rowAddr_C) * IDX_W'(MAT_DIM) + IDX_W'(colAddr_C);
  assign rd_idx    = IDX_W'(ptr_row) * IDX_W'(MAT_DIM) + IDX_W'(ptr_col);
  assign elem_data = mem[rd_idx];
  assign xfer      = out_valid && out_ready;
  assign at_last   = (ptr_row == MAX_ROW) && (ptr_col == LAST_COL);
  assign out_row   = ptr_row;
  assign out_col   = ptr_col;
  assign out_last  = out_valid && at_last;

`ifdef ROW_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] row_sum;
  assign out_data = (ptr_col == 4'(MAT_DIM)) ? row_sum : elem_data;
`else
  assign out_data = elem_data;
`endif

  // Data store has no reset; the fill bitmap alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= writeData_C;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= COLLECT;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      fill_count   <= '0;
      invalid_seen <= 1'b0;
      addr_err     <= 1'b0;
      overrun_err  <= 1'b0;
      filled       <= '0;
      ptr_row      <= '0;
      ptr_col      <= '0;
`ifdef ROW_CHECKSUM_EN
      row_sum      <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        COLLECT: begin
          if (en_WriteMat_C) begin
            if (in_range) begin
              if (resultIsInvalid) invalid_seen <= 1'b1;
              if (!filled[wr_idx]) begin
                filled[wr_idx] <= 1'b1;
                fill_count     <= fill_count + 7'd1;
                if (fill_count == 7'(DEPTH - 1)) begin
                  state     <= DRAIN;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  ptr_row   <= '0;
                  ptr_col   <= '0;
`ifdef ROW_CHECKSUM_EN
                  row_sum   <= '0;
`endif
                end
              end
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (en_WriteMat_C) overrun_err <= 1'b1;
          if (xfer) begin
            if (at_last) begin
              state      <= DONE;
              out_valid  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              ptr_row    <= '0;
              ptr_col    <= '0;
            end else if (ptr_col == LAST_COL) begin
              ptr_row <= ptr_row + 4'd1;
              ptr_col <= '0;
`ifdef ROW_CHECKSUM_EN
              row_sum <= '0;
`endif
            end else begin
              ptr_col <= ptr_col + 4'd1;
`ifdef ROW_CHECKSUM_EN
              // Checksum beat is the column after ELEM_END, so only element beats accumulate.
              if (ptr_col <= ELEM_END) row_sum <= row_sum + elem_data;
`endif
            end
          end
        end
        DONE: begin
          filled       <= '0;
          fill_count   <= '0;
          invalid_seen <= 1'b0;
          addr_err     <= 1'b0;
          // A write landing in this cycle is charged to the frame about to start.
          overrun_err  <= en_WriteMat_C;
          state        <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_c_result_streamer.sv
// Directed bench for matrix_c_result_streamer (default build, no checksum beats).
module tb_matrix_c_result_streamer;
  localparam int DW = 8;
  localparam int MD = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [3:0]    row_a, col_a;
  logic [DW-1:0] wdata;
  logic          inval;
  logic          out_valid, out_ready, out_last, busy, frame_done;
  logic [DW-1:0] out_data;
  logic [3:0]    out_row, out_col;
  logic [6:0]    fill_count;
  logic          invalid_seen, addr_err, overrun_err;

  matrix_c_result_streamer #(.DATA_WIDTH(DW), .MAT_DIM(MD)) dut (
    .clk(clk), .reset_n(reset_n), .en_WriteMat_C(en), .rowAddr_C(row_a),
    .colAddr_C(col_a), .writeData_C(wdata), .resultIsInvalid(inval),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy),
    .frame_done(frame_done), .fill_count(fill_count), .invalid_seen(invalid_seen),
    .addr_err(addr_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] model [100];
  bit            tb_filled [100];

  typedef struct {
    logic       en;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] data;
    logic       inv;
    int         exp_fill;
    logic       exp_addr;
    logic       exp_inv;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input int c, input logic [7:0] d, input logic inv);
    en = 1'b1; row_a = 4'(r); col_a = 4'(c); wdata = d; inval = inv;
    tick();
    en = 1'b0; inval = 1'b0;
    if (r < MD && c < MD) begin
      model[r*MD+c]     = d;
      tb_filled[r*MD+c] = 1'b1;
    end
  endtask

  task automatic fill_rest(input int off);
    for (int i = 0; i < 100; i++)
      if (!tb_filled[i]) wr(i / MD, i % MD, 8'(i + off), 1'b0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles every cycle.
  task automatic drain(input int mode, input bit done_wr);
    int beats = 0;
    int cyc = 0;
    while (beats < 100 && cyc < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (!out_valid) begin
        chk("drain_valid", {31'd0, out_valid}, 32'd1);
        break;
      end
      chk("beat_row",  {28'd0, out_row}, 32'(beats / MD));
      chk("beat_col",  {28'd0, out_col}, 32'(beats % MD));
      chk("beat_data", {24'd0, out_data}, {24'd0, model[beats]});
      chk("beat_last", {31'd0, out_last}, 32'(beats == 99));
      chk("beat_busy", {31'd0, busy}, 32'd1);
      if (out_ready) beats++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk("beat_total", 32'(beats), 32'd100);
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    chk("done_busy",  {31'd0, busy}, 32'd0);
    if (done_wr) begin
      en = 1'b1; row_a = 4'd0; col_a = 4'd0; wdata = 8'hEE;
    end
    tick();
    en = 1'b0;
    chk("pulse_end",  {31'd0, frame_done}, 32'd0);
    chk("fill_clr",   {25'd0, fill_count}, 32'd0);
    chk("inv_clr",    {31'd0, invalid_seen}, 32'd0);
    chk("addr_clr",   {31'd0, addr_err}, 32'd0);
    chk("overrun_nf", {31'd0, overrun_err}, 32'(done_wr));
    for (int i = 0; i < 100; i++) tb_filled[i] = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'hB, 4'd2, 8'h11, 1'b0, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'd0, 4'd0, 8'h21, 1'b0, 1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd0, 4'd0, 8'h22, 1'b0, 1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 4'd5, 4'd5, 8'h33, 1'b1, 2, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 4'd2, 4'hA, 8'h44, 1'b0, 2, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'd0, 4'd1, 8'h55, 1'b0, 3, 1'b1, 1'b1};

    reset_n = 1'b0; en = 1'b0; row_a = '0; col_a = '0; wdata = '0; inval = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 100; i++) tb_filled[i] = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_fill",  {25'd0, fill_count}, 32'd0);
    chk("rst_flags", {29'd0, invalid_seen, addr_err, overrun_err}, 32'd0);
    chk("rst_ptr",   {24'd0, out_row, out_col}, 32'd0);
    chk("rst_done",  {30'd0, frame_done, out_last}, 32'd0);

    // Row-major ramp 0..99.
    for (int i = 0; i < 99; i++) wr(i / MD, i % MD, 8'(i), 1'b0);
    chk("ramp_fill99",  {25'd0, fill_count}, 32'd99);
    chk("ramp_novalid", {31'd0, out_valid}, 32'd0);
    wr(9, 9, 8'd99, 1'b0);
    chk("ramp_fill100", {25'd0, fill_count}, 32'd100);
    chk("ramp_valid",   {31'd0, out_valid}, 32'd1);
    drain(0, 1'b0);

    // Reverse order with a duplicate at [3][4], drained with toggling ready.
    for (int i = 99; i >= 0; i--) begin
      if (i == 34) begin
        wr(3, 4, 8'd7, 1'b0);
        wr(3, 4, 8'd42, 1'b0);
        chk("dup_fill", {25'd0, fill_count}, 32'd66);
      end else begin
        wr(i / MD, i % MD, 8'(i), 1'b0);
      end
      if (i == 1) chk("rev_novalid", {31'd0, out_valid}, 32'd0);
    end
    chk("rev_fill100", {25'd0, fill_count}, 32'd100);
    chk("rev_valid",   {31'd0, out_valid}, 32'd1);
    drain(1, 1'b0);

    // Bad address and invalid-result flags from the vector table.
    for (int k = 0; k < 7; k++) begin
      en = vecs[k].en; row_a = vecs[k].row; col_a = vecs[k].col;
      wdata = vecs[k].data; inval = vecs[k].inv;
      tick();
      en = 1'b0; inval = 1'b0;
      if (vecs[k].en && vecs[k].row < MD && vecs[k].col < MD) begin
        model[vecs[k].row*MD+vecs[k].col]     = vecs[k].data;
        tb_filled[vecs[k].row*MD+vecs[k].col] = 1'b1;
      end
      chk($sformatf("vec%0d_fill", k), {25'd0, fill_count}, 32'(vecs[k].exp_fill));
      chk($sformatf("vec%0d_addr", k), {31'd0, addr_err}, {31'd0, vecs[k].exp_addr});
      chk($sformatf("vec%0d_inv", k),  {31'd0, invalid_seen}, {31'd0, vecs[k].exp_inv});
    end
    fill_rest(3);
    chk("flag_addr_drain", {31'd0, addr_err}, 32'd1);
    chk("flag_inv_drain",  {31'd0, invalid_seen}, 32'd1);
    drain(0, 1'b0);

    // Overrun during DRAIN, then reset at beat 37.
    fill_rest(5);
    chk("ovr_valid", {31'd0, out_valid}, 32'd1);
    en = 1'b1; row_a = 4'd0; col_a = 4'd0; wdata = 8'hA5; out_ready = 1'b0;
    tick();
    en = 1'b0;
    chk("ovr_flag",  {31'd0, overrun_err}, 32'd1);
    chk("ovr_hold",  {24'd0, out_data}, {24'd0, model[0]});
    out_ready = 1'b1;
    for (int b = 0; b < 37; b++) tick();
    chk("b37_ptr",   {24'd0, out_row, out_col}, 32'h37);
    chk("b37_data",  {24'd0, out_data}, {24'd0, model[37]});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; out_ready = 1'b0;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_fill",  {25'd0, fill_count}, 32'd0);
    chk("mrst_ovr",   {31'd0, overrun_err}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    for (int i = 0; i < 100; i++) tb_filled[i] = 1'b0;
    wr(2, 3, 8'h77, 1'b0);
    chk("mrst_collect", {25'd0, fill_count}, 32'd1);

    // Complete the frame; a write in the DONE cycle charges the next frame.
    fill_rest(9);
    drain(0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
